// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: multi-cycle data-memory controller for the MIPS MEM stage.
// Sequences one access to a single-port synchronous SRAM with a fixed number
// of wait cycles, holding freeze high while the access is in flight.
// Optional feature macro: MEM_ADDR_CHECK_EN (out-of-range request detection).
module mem_access_ctrl #(
    parameter int          WAIT_CYCLES = 5,
    parameter int          ADDR_W      = 16,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_R_EN,
    input  logic              MEM_W_EN,
    input  logic [31:0]       ALU_result,
    input  logic [31:0]       ST_Val,
    input  logic [31:0]       sram_rdata,
    output logic              freeze,
    output logic [31:0]       rd_data,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output logic              addr_err
);

    // Counter only has to reach WAIT_CYCLES-2.
    localparam int CNT_W = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic             is_write;
    logic             req;
    logic [31:0]      offset;
    logic             out_of_range;
    logic             freeze_c;
    logic             unused_offset_bits;

    assign req    = MEM_R_EN | MEM_W_EN;
    assign offset = ALU_result - BASE_ADDR;

    // Byte-lane bits and bits above the word window only matter to the range check.
    assign unused_offset_bits = ^{offset[31:ADDR_W+2], offset[1:0]};

`ifdef MEM_ADDR_CHECK_EN
    // Out of range: below the base, unaligned, or past the top SRAM word.
    assign out_of_range = (ALU_result < BASE_ADDR) ||
                          (ALU_result[1:0] != 2'b00) ||
                          ((offset >> (ADDR_W + 2)) != 32'd0);

    // One-cycle error pulse in the cycle after a rejected request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_err <= 1'b0;
        end else begin
            addr_err <= (state == IDLE) && req && out_of_range;
        end
    end
`else
    assign out_of_range = 1'b0;
    assign addr_err     = 1'b0;
`endif

    // State register, access counter and latched transaction fields.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            is_write   <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            rd_data    <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (req) begin
                        is_write <= MEM_W_EN;
                        cnt      <= '0;
                        if (out_of_range) begin
                            if (!MEM_W_EN) begin
                                rd_data <= '0;
                            end
                        end else begin
                            sram_addr  <= offset[ADDR_W+1:2];
                            sram_wdata <= ST_Val;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == CNT_LAST) begin
                        if (!is_write) begin
                            rd_data <= sram_rdata;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    // DONE: the completed instruction is still presented; hold everything.
                end
            endcase
        end
    end

    // Next-state decode plus freeze and SRAM strobes.
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        next_state = state;
        freeze_c   = 1'b0;
        sram_we_n  = 1'b1;
        sram_oe_n  = 1'b1;
        case (state)
            IDLE: begin
                if (req) begin
                    freeze_c   = !out_of_range;
                    next_state = out_of_range ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                freeze_c  = 1'b1;
                sram_we_n = !is_write;
                sram_oe_n = is_write;
                if (cnt == CNT_LAST) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Reset holds the pipeline free-running even if a request is presented.
    assign freeze = freeze_c & rst;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl with a behavioural SRAM model and a
// scoreboard of expected rd_data values checked at each completion cycle.
module tb_mem_access_ctrl;

    localparam int          WAIT = 5;
    localparam logic [31:0] BASE = 32'd1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] ALU_result;
    logic [31:0] ST_Val;
    logic [31:0] sram_rdata;
    logic        freeze;
    logic [31:0] rd_data;
    logic [15:0] sram_addr;
    logic [31:0] sram_wdata;
    logic        sram_we_n;
    logic        sram_oe_n;
    logic        addr_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] last_rd = 32'd0;

    // SRAM contents (written only by the DUT) and the bench's golden copy.
    logic [31:0] sram_mem   [0:65535];
    bit          sram_wr    [0:65535];
    logic [31:0] gold_mem   [0:65535];
    bit          gold_wr    [0:65535];

    mem_access_ctrl #(
        .WAIT_CYCLES(WAIT),
        .ADDR_W     (16),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .MEM_R_EN  (MEM_R_EN),
        .MEM_W_EN  (MEM_W_EN),
        .ALU_result(ALU_result),
        .ST_Val    (ST_Val),
        .sram_rdata(sram_rdata),
        .freeze    (freeze),
        .rd_data   (rd_data),
        .sram_addr (sram_addr),
        .sram_wdata(sram_wdata),
        .sram_we_n (sram_we_n),
        .sram_oe_n (sram_oe_n),
        .addr_err  (addr_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input logic [15:0] a);
        return (a == 16'd2) ? 32'h1234_5678 : {16'hC0DE, a};
    endfunction

    // Synchronous-write SRAM; read data visible while output enable is low.
    always @(posedge clk) begin
        if (!sram_we_n) begin
            sram_mem[sram_addr] <= sram_wdata;
            sram_wr[sram_addr]  <= 1'b1;
        end
    end

    assign sram_rdata = sram_oe_n ? 32'hBAD0_BAD0 :
                        (sram_wr[sram_addr] ? sram_mem[sram_addr] : init_val(sram_addr));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] word_of(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        return o[17:2];
    endfunction

    function automatic logic [31:0] gold_rd(input logic [15:0] a);
        return gold_wr[a] ? gold_mem[a] : init_val(a);
    endfunction

    // One memory instruction: drives it at the next negedge (cycle 0) and
    // follows it to its DONE cycle, checking timing, strobes and data.
    task automatic access(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input bit drop_early);
        int          fz, we, oe, cyc;
        logic [15:0] wa;
        logic [31:0] seen_addr, seen_wdata;
        wa = word_of(a);
        if (w) begin
            gold_mem[wa] = d;
            gold_wr[wa]  = 1'b1;
        end else begin
            last_rd = gold_rd(wa);
        end
        exp_q.push_back(last_rd);

        @(negedge clk);
        MEM_R_EN   = r;
        MEM_W_EN   = w;
        ALU_result = a;
        ST_Val     = d;
        #1;
        fz = 0; we = 0; oe = 0; cyc = 0;
        seen_addr  = 32'hFFFF_FFFF;
        seen_wdata = 32'hFFFF_FFFF;
        while (freeze === 1'b1 && cyc < 20) begin
            fz++;
            if (sram_we_n === 1'b0) we++;
            if (sram_oe_n === 1'b0) oe++;
            if (cyc == 1) begin
                seen_addr  = {16'd0, sram_addr};
                seen_wdata = sram_wdata;
            end
            @(negedge clk);
            cyc++;
            if (drop_early && cyc == 2) begin
                MEM_R_EN = 1'b0;
                MEM_W_EN = 1'b0;
            end
            #1;
        end
        check("freeze_cycles", fz, WAIT);
        check("we_low_cycles", we, w ? WAIT - 1 : 0);
        check("oe_low_cycles", oe, (r && !w) ? WAIT - 1 : 0);
        check("sram_addr", seen_addr, {16'd0, wa});
        if (w) check("sram_wdata", seen_wdata, d);
        // DONE cycle: freeze low even with the request still presented.
        check("done_freeze", {31'd0, freeze}, 32'd0);
        check("done_strobes", {30'd0, sram_we_n, sram_oe_n}, 32'd3);
        check("done_addr_err", {31'd0, addr_err}, 32'd0);
        if (exp_q.size() > 0) check("rd_data", rd_data, exp_q.pop_front());
        else check("scoreboard_empty", 32'd1, 32'd0);
        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b0;
    endtask

    initial begin
        int fz;
        rst        = 1'b0;
        MEM_R_EN   = 1'b0;
        MEM_W_EN   = 1'b0;
        ALU_result = 32'd0;
        ST_Val     = 32'd0;

        // Reset state.
        #1;
        check("rst_freeze", {31'd0, freeze}, 32'd0);
        check("rst_strobes", {30'd0, sram_we_n, sram_oe_n}, 32'd3);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rel_rd_data", rd_data, 32'd0);
        check("rel_sram_addr", {16'd0, sram_addr}, 32'd0);
        check("rel_sram_wdata", sram_wdata, 32'd0);
        check("rel_strobes", {30'd0, sram_we_n, sram_oe_n}, 32'd3);
        check("rel_addr_err", {31'd0, addr_err}, 32'd0);
        fz = 0;
        repeat (10) begin
            @(negedge clk);
            #1;
            if (freeze !== 1'b0) fz++;
        end
        check("idle_freeze", fz, 0);

        // Store, load, store holding rd_data.
        access(1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF, 1'b0);
        access(1'b1, 1'b0, 32'd1032, 32'd0, 1'b0);
        access(1'b0, 1'b1, 32'd1036, 32'h0BAD_F00D, 1'b0);
        // Back-to-back load then store (starts at cycle 6 of the load).
        access(1'b1, 1'b0, 32'd1028, 32'd0, 1'b0);
        access(1'b0, 1'b1, 32'd1040, 32'h5555_AAAA, 1'b0);
        // Both enables: write only, rd_data unchanged.
        access(1'b1, 1'b1, 32'd1044, 32'hCAFE_F00D, 1'b0);
        // Request dropped during ACCESS still completes.
        access(1'b1, 1'b0, 32'd1044, 32'd0, 1'b1);
`ifndef MEM_ADDR_CHECK_EN
        // Truncation: byte-lane bits ignored, below-base wraps.
        access(1'b1, 1'b0, 32'd1031, 32'd0, 1'b0);
        access(1'b1, 1'b0, 32'd1000, 32'd0, 1'b0);
`endif

        // Reset during cycle 2 of a read aborts it asynchronously.
        @(negedge clk);
        MEM_R_EN   = 1'b1;
        ALU_result = 32'd1036;
        repeat (2) @(negedge clk);
        #1;
        check("pre_abort_oe", {31'd0, sram_oe_n}, 32'd0);
        rst = 1'b0;
        #1;
        check("abort_strobes", {30'd0, sram_we_n, sram_oe_n}, 32'd3);
        check("abort_freeze", {31'd0, freeze}, 32'd0);
        check("abort_rd_data", rd_data, 32'd0);
        MEM_R_EN = 1'b0;
        last_rd  = 32'd0;
        @(negedge clk);
        rst = 1'b1;
        access(1'b1, 1'b0, 32'd1040, 32'd0, 1'b0);

`ifdef MEM_ADDR_CHECK_EN
        // Out-of-range read: no freeze, one addr_err pulse, rd_data cleared.
        begin
            int ae, oe;
            fz = 0; ae = 0; oe = 0;
            @(negedge clk);
            MEM_R_EN   = 1'b1;
            ALU_result = 32'd1000;
            #1;
            repeat (6) begin
                if (freeze !== 1'b0) fz++;
                if (addr_err === 1'b1) ae++;
                if (sram_oe_n !== 1'b1) oe++;
                @(negedge clk);
                MEM_R_EN = 1'b0;
                #1;
            end
            check("oor_freeze", fz, 0);
            check("oor_addr_err", ae, 1);
            check("oor_oe", oe, 0);
            check("oor_rd_data", rd_data, 32'd0);
        end
`endif

        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Multi-cycle data-memory controller for the MEM stage of the 5-stage MIPS pipeline. It takes the EXE/MEM pipeline register's memory-read/write enables, ALU result (byte address) and store value, and sequences an access to an external single-port synchronous SRAM with a fixed number of wait cycles. While an access is in flight it holds `freeze` high so the hazard logic stalls the PC and all pipeline registers. It returns load data with a one-cycle completion window.

## Interface
- `WAIT_CYCLES`, 5: total stall cycles per access; legal range ≥ 2.
- `ADDR_W`, 16: SRAM word-address width.
- `BASE_ADDR`, 1024: byte address mapped to SRAM word 0.
- `clk` in 1: pipeline clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `MEM_R_EN` in 1: load request from the EXE/MEM register.
- `MEM_W_EN` in 1: store request from the EXE/MEM register.
- `ALU_result` in 32: byte address.
- `ST_Val` in 32: store data.
- `sram_rdata` in 32: SRAM read data, valid in the same cycle `sram_oe_n` is low.
- `freeze` out 1: stall request to the PC and pipeline registers.
- `rd_data` out 32: load result for the MEM/WB register.
- `sram_addr` out ADDR_W: SRAM word address (registered).
- `sram_wdata` out 32: SRAM write data (registered).
- `sram_we_n` out 1: active-low write strobe.
- `sram_oe_n` out 1: active-low output enable.
- `addr_err` out 1: one-cycle out-of-range pulse. Driven 0 when `MEM_ADDR_CHECK_EN` is undefined.

## Operation
- States: IDLE, ACCESS, DONE. `req = MEM_R_EN | MEM_W_EN`. If both enables are high, the access is a write and the read is ignored.
- IDLE:
  - `freeze = req` (combinational).
  - On a clock edge with `req` high: latch `sram_addr = (ALU_result - BASE_ADDR)[ADDR_W+1:2]` using 32-bit unsigned subtraction with wrap; bits [1:0] are ignored.
  - On the same edge: latch `sram_wdata = ST_Val`, latch the write/read type, clear the counter, and go to ACCESS.
- ACCESS:
  - `freeze = 1`.
  - `sram_we_n = 0` for a write; `sram_oe_n = 0` for a read; the other strobe stays 1.
  - The counter increments every cycle. When it reaches `WAIT_CYCLES-2`, the block goes to DONE; on that edge a read also captures `sram_rdata` into `rd_data`.
- DONE:
  - `freeze = 0` and both strobes are 1.
  - Requests are ignored, because the EXE/MEM register is still presenting the completed instruction.
  - Unconditionally returns to IDLE.
- `rd_data` holds its value until the next read capture. Writes do not change it.

## Timing
- Reset (`rst` low): state IDLE, counter 0, `rd_data`/`sram_addr`/`sram_wdata` 0, `sram_we_n`/`sram_oe_n` 1, `addr_err` 0. `freeze` is forced 0 while `rst` is low.
- Reset in mid-access aborts the access immediately: strobes go inactive asynchronously and no data is captured.
- Request sampled in IDLE at cycle 0:
  - `freeze` is high in cycles 0..WAIT_CYCLES-1, i.e. exactly WAIT_CYCLES cycles.
  - ACCESS occupies cycles 1..WAIT_CYCLES-1.
  - DONE is at cycle WAIT_CYCLES, with `rd_data` valid and `freeze` 0.
- Back-to-back memory instructions: the next request can be accepted in IDLE at cycle WAIT_CYCLES+1.
- A request that drops during ACCESS does not cancel the access.

## Configuration
- Macro `MEM_ADDR_CHECK_EN`, defined: a request is out of range when any of the following hold:
  - `ALU_result < BASE_ADDR`;
  - `ALU_result[1:0] != 0`;
  - `(ALU_result - BASE_ADDR) >> 2 >= 2**ADDR_W`.
- Handling of an out-of-range request in IDLE:
  - `freeze` is low and no strobes are asserted.
  - `addr_err` pulses high for the cycle after the request edge; the state goes straight to DONE.
  - For a read, `rd_data` is loaded with 0.
- Macro undefined: no range checking; the address is truncated as described in Operation; `addr_err` is tied to 0.

## Test plan
- Reset release: after `rst` rises, all outputs are at their reset values; with no request, `freeze` stays 0 indefinitely.
- Store, `WAIT_CYCLES=5`: `MEM_W_EN=1`, `ALU_result=1028`, `ST_Val=0xDEADBEEF` → `freeze` high for 5 cycles; `sram_addr=1`, `sram_wdata=0xDEADBEEF`, `sram_we_n` low for 4 cycles; `sram_oe_n` stays 1.
- Load: `MEM_R_EN=1`, `ALU_result=1032`, SRAM model returns `0x12345678` at word 2 → `rd_data=0x12345678` in the DONE cycle with `freeze` 0; the value is held through a following store.
- Back-to-back: load then store → second access starts at cycle 6, with one DONE cycle between the two freeze windows; both R and W high → write only.
- Reset at cycle 2 of a read → strobes high and `freeze` 0 immediately, `rd_data` 0, then a clean new access.
- `MEM_ADDR_CHECK_EN` defined, `MEM_R_EN=1`, `ALU_result=1000` → `freeze` never high, one `addr_err` pulse, `rd_data=0`, `sram_oe_n` stays 1.
